// File: rtl/vid_sync_rx.sv
// vid_sync_rx: video sync receiver. Registers the incoming pixel stream,
// produces pixel coordinates, measures active frame geometry and reports
// lock once LOCK_FRAMES consecutive good frames agree.
// Optional feature: define VID_SYNC_RX_CKSUM_EN to add the frame_cksum
// output (mod 2^24 sum of the active pixels of the last completed frame).
module vid_sync_rx #(
    parameter bit HS_POL      = 1'b0,
    parameter bit VS_POL      = 1'b0,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        clk_25,
    input  logic        rst,
    input  logic        vid_de,
    input  logic        vid_hs,
    input  logic        vid_vs,
    input  logic [23:0] vid_data,
    output logic        pix_valid,
    output logic [23:0] pix_data,
    output logic [10:0] pix_x,
    output logic [10:0] pix_y,
    output logic        frame_start,
    output logic [10:0] h_active,
    output logic [10:0] v_active,
    output logic        locked,
    output logic        err
`ifdef VID_SYNC_RX_CKSUM_EN
    ,
    output logic [23:0] frame_cksum
`endif
);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    localparam logic [3:0] LOCK_CNT = 4'(LOCK_FRAMES);

    // 11-bit counters stick at their maximum instead of wrapping
    function automatic logic [10:0] sat_inc(input logic [10:0] v);
        return (v == 11'h7FF) ? v : v + 11'd1;
    endfunction

    state_t      r_state;
    logic        r_de_p0;
    logic        r_hs_p0;
    logic        r_vs_p0;
    logic [10:0] r_run;
    logic [10:0] r_first_run;
    logic        r_have_first;
    logic        r_bad;
    logic        r_in_frame;
    logic [3:0]  r_match_cnt;

    logic        w_hs_act;
    logic        w_vs_act;
    logic        w_de_rise;
    logic        w_de_fall;
    logic        w_hs_edge;
    logic        w_vs_edge;
    logic        w_run_mismatch;
    logic        w_close_bad;
    logic [10:0] w_close_lines;
    logic [10:0] w_close_h;
    logic        w_good;
    logic        w_geom_eq;
    logic [3:0]  w_cnt_inc;

    // Sync levels normalised to "active", plus edge detection against the previous sample
    assign w_hs_act  = (vid_hs == HS_POL);
    assign w_vs_act  = (vid_vs == VS_POL);
    assign w_de_rise = vid_de & ~r_de_p0;
    assign w_de_fall = ~vid_de & r_de_p0;
    assign w_hs_edge = w_hs_act & ~r_hs_p0;
    assign w_vs_edge = w_vs_act & ~r_vs_p0;

    // Frame closure view: a line ending in the same cycle as the VS edge is folded in first
    assign w_run_mismatch = w_de_fall & r_have_first & (r_run != r_first_run);
    assign w_close_bad    = r_bad | w_run_mismatch;
    assign w_close_lines  = w_de_fall ? sat_inc(pix_y) : pix_y;
    assign w_close_h      = r_have_first ? r_first_run : r_run;
    assign w_good         = r_in_frame & ~w_close_bad & (w_close_lines != 11'd0);
    assign w_geom_eq      = (w_close_h == h_active) & (w_close_lines == v_active);
    assign w_cnt_inc      = r_match_cnt + 4'd1;

    // Edge history always tracks the inputs, so reset leaves no stale edge behind
    always_ff @(posedge clk_25) begin
        r_de_p0 <= vid_de;
        r_hs_p0 <= w_hs_act;
        r_vs_p0 <= w_vs_act;
    end

    // Pixel output stage: one register between input and output, column counter
    always_ff @(posedge clk_25) begin
        if (rst) begin
            pix_valid <= 1'b0;
            pix_data  <= 24'd0;
            pix_x     <= 11'd0;
        end else begin
            pix_valid <= vid_de;
            pix_data  <= vid_data;
            if (vid_de) begin
                pix_x <= w_de_rise ? 11'd0 : sat_inc(pix_x);
            end
        end
    end

    // Run length (cleared only by HS), line counter and per-frame line consistency
    always_ff @(posedge clk_25) begin
        if (rst) begin
            r_run        <= 11'd0;
            r_first_run  <= 11'd0;
            r_have_first <= 1'b0;
            r_bad        <= 1'b0;
            pix_y        <= 11'd0;
        end else begin
            if (w_hs_edge) begin
                r_run <= vid_de ? 11'd1 : 11'd0;
            end else if (vid_de) begin
                r_run <= sat_inc(r_run);
            end

            if (w_vs_edge) begin
                pix_y        <= 11'd0;
                r_have_first <= 1'b0;
                r_bad        <= 1'b0;
            end else if (w_de_fall) begin
                pix_y <= sat_inc(pix_y);
                if (!r_have_first) begin
                    r_first_run  <= r_run;
                    r_have_first <= 1'b1;
                end else if (w_run_mismatch) begin
                    r_bad <= 1'b1;
                end
            end
        end
    end

    // Lock FSM: evaluates the completed frame at every VS edge, drives locked/err/geometry
    always_ff @(posedge clk_25) begin
        if (rst) begin
            r_state     <= SEARCH;
            r_match_cnt <= 4'd0;
            r_in_frame  <= 1'b0;
            frame_start <= 1'b0;
            err         <= 1'b0;
            locked      <= 1'b0;
            h_active    <= 11'd0;
            v_active    <= 11'd0;
        end else begin
            frame_start <= w_vs_edge;
            err         <= vid_de & w_vs_act;
            if (w_vs_edge) begin
                r_in_frame <= 1'b1;
                case (r_state)
                    SEARCH: begin
                        r_state     <= MEASURE;
                        r_match_cnt <= 4'd0;
                        if (w_good) begin
                            h_active <= w_close_h;
                            v_active <= w_close_lines;
                        end
                    end
                    MEASURE: begin
                        if (w_good && w_geom_eq) begin
                            r_match_cnt <= w_cnt_inc;
                            if (w_cnt_inc == LOCK_CNT) begin
                                r_state <= LOCKED;
                                locked  <= 1'b1;
                            end
                        end else if (w_good) begin
                            h_active    <= w_close_h;
                            v_active    <= w_close_lines;
                            r_match_cnt <= 4'd1;
                            if (LOCK_CNT == 4'd1) begin
                                r_state <= LOCKED;
                                locked  <= 1'b1;
                            end
                        end else begin
                            // bad or empty frame restarts the match run with nothing stored
                            r_match_cnt <= 4'd0;
                        end
                    end
                    LOCKED: begin
                        if (!w_good || !w_geom_eq) begin
                            err         <= 1'b1;
                            locked      <= 1'b0;
                            r_state     <= SEARCH;
                            r_match_cnt <= 4'd0;
                        end
                    end
                    default: begin
                        r_state <= SEARCH;
                        locked  <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef VID_SYNC_RX_CKSUM_EN
    logic [23:0] r_sum;

    // Running sum of active pixels, latched into frame_cksum at each VS edge
    always_ff @(posedge clk_25) begin
        if (rst) begin
            r_sum       <= 24'd0;
            frame_cksum <= 24'd0;
        end else if (w_vs_edge) begin
            frame_cksum <= r_sum;
            r_sum       <= vid_de ? vid_data : 24'd0;
        end else if (vid_de) begin
            r_sum <= r_sum + vid_data;
        end
    end
`endif

endmodule

// File: tb/tb_vid_sync_rx.sv
// Testbench for vid_sync_rx: two instances (active-low and active-high syncs)
// fed the same reduced-size video raster; pixels checked through a scoreboard.
module tb_vid_sync_rx;

    localparam int H_ACT     = 40;
    localparam int H_TOT     = 56;
    localparam int HS_S      = 44;
    localparam int HS_E      = 50;
    localparam int V_ACT     = 12;
    localparam int V_TOT     = 20;
    localparam int VS_W      = 2;
    localparam int VB        = 5;
    localparam int SHORT_ROW = 5;
    localparam int RST_ROW   = 8;

    typedef struct {
        int          x;
        int          y;
        logic [23:0] d;
    } pix_t;

    logic        clk_25 = 1'b0;
    logic        rst = 1'b1;
    logic        vid_de = 1'b0;
    logic        vid_hs0 = 1'b1;
    logic        vid_vs0 = 1'b1;
    logic        vid_hs1 = 1'b0;
    logic        vid_vs1 = 1'b0;
    logic [23:0] vid_data = 24'd0;

    logic        pix_valid0, pix_valid1;
    logic [23:0] pix_data0, pix_data1;
    logic [10:0] pix_x0, pix_x1, pix_y0, pix_y1;
    logic        frame_start0, frame_start1;
    logic [10:0] h_active0, h_active1, v_active0, v_active1;
    logic        locked0, locked1, err0, err1;
`ifdef VID_SYNC_RX_CKSUM_EN
    logic [23:0] ck0, ck1;
`endif

    pix_t        sb_q[$];
    int          n_chk = 0;
    int          n_err = 0;
    int          e_locked = 0;
    int          e_h = 0;
    int          e_v = 0;
    logic [23:0] b_sum = 24'd0;
    logic [23:0] e_ck = 24'd0;

    always #5 clk_25 = ~clk_25;

    vid_sync_rx dut0 (
        .clk_25(clk_25), .rst(rst), .vid_de(vid_de), .vid_hs(vid_hs0), .vid_vs(vid_vs0),
        .vid_data(vid_data), .pix_valid(pix_valid0), .pix_data(pix_data0),
        .pix_x(pix_x0), .pix_y(pix_y0), .frame_start(frame_start0),
        .h_active(h_active0), .v_active(v_active0), .locked(locked0), .err(err0)
`ifdef VID_SYNC_RX_CKSUM_EN
        , .frame_cksum(ck0)
`endif
    );

    vid_sync_rx #(.HS_POL(1'b1), .VS_POL(1'b1), .LOCK_FRAMES(2)) dut1 (
        .clk_25(clk_25), .rst(rst), .vid_de(vid_de), .vid_hs(vid_hs1), .vid_vs(vid_vs1),
        .vid_data(vid_data), .pix_valid(pix_valid1), .pix_data(pix_data1),
        .pix_x(pix_x1), .pix_y(pix_y1), .frame_start(frame_start1),
        .h_active(h_active1), .v_active(v_active1), .locked(locked1), .err(err1)
`ifdef VID_SYNC_RX_CKSUM_EN
        , .frame_cksum(ck1)
`endif
    );

    task automatic check_val(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one clock of stimulus (sync arguments are "active" levels), then check outputs
    task automatic step(input logic de, input logic hs, input logic vs, input logic fs,
                        input logic er, input int x, input int y);
        logic [23:0] d;
        pix_t        p;
        logic        in_rst;
        d        = 24'($urandom);
        in_rst   = rst;
        vid_de   = de;
        vid_hs0  = ~hs;
        vid_vs0  = ~vs;
        vid_hs1  = hs;
        vid_vs1  = vs;
        vid_data = d;
        if (de && !in_rst) sb_q.push_back('{x: x, y: y, d: d});
        if (fs) begin
            e_ck  = b_sum;
            b_sum = 24'd0;
        end
        if (de && !in_rst) b_sum = b_sum + d;
        @(posedge clk_25);
        #1;
        check_val("fs0", int'(frame_start0), int'(fs));
        check_val("fs1", int'(frame_start1), int'(fs));
        check_val("err0", int'(err0), int'(er));
        check_val("err1", int'(err1), int'(er));
        check_val("lock0", int'(locked0), e_locked);
        check_val("lock1", int'(locked1), e_locked);
        check_val("hact0", int'(h_active0), e_h);
        check_val("hact1", int'(h_active1), e_h);
        check_val("vact0", int'(v_active0), e_v);
        check_val("vact1", int'(v_active1), e_v);
        check_val("pv0", int'(pix_valid0), int'(de & ~in_rst));
        check_val("pv1", int'(pix_valid1), int'(de & ~in_rst));
`ifdef VID_SYNC_RX_CKSUM_EN
        check_val("ck0", int'(ck0), int'(e_ck));
        check_val("ck1", int'(ck1), int'(e_ck));
`endif
        if (sb_q.size() != 0) begin
            p = sb_q.pop_front();
            check_val("px0", int'(pix_x0), p.x);
            check_val("px1", int'(pix_x1), p.x);
            check_val("py0", int'(pix_y0), p.y);
            check_val("py1", int'(pix_y1), p.y);
            check_val("pd0", int'(pix_data0), int'(p.d));
            check_val("pd1", int'(pix_data1), int'(p.d));
        end
    endtask

    task automatic chk_reset_zero();
        check_val("rst_px0", int'(pix_x0), 0);
        check_val("rst_px1", int'(pix_x1), 0);
        check_val("rst_py0", int'(pix_y0), 0);
        check_val("rst_py1", int'(pix_y1), 0);
        check_val("rst_pd0", int'(pix_data0), 0);
        check_val("rst_pd1", int'(pix_data1), 0);
    endtask

    // mode 0 normal, 1 one short line, 2 one-cycle reset mid-frame, 3 DE pulse while VS active
    task automatic gen_frame(input int mode, input logic fs_err, input int lk,
                             input int hh, input int vv);
        int yoff;
        yoff = (mode == 3) ? 1 : 0;
        for (int v = 0; v < V_TOT; v++) begin
            for (int h = 0; h < H_TOT; h++) begin
                logic vs, hs, de, fs, er;
                int   row, x, y;
                row = v - VB;
                vs  = (v < VS_W);
                hs  = (h >= HS_S) && (h < HS_E);
                de  = (v >= VB) && (v < VB + V_ACT) && (h < H_ACT);
                if (mode == 1 && row == SHORT_ROW && h == H_ACT - 1) de = 1'b0;
                fs  = (v == 0) && (h == 0);
                er  = 1'b0;
                x   = h;
                y   = row + yoff;
                if (fs) begin
                    e_locked = lk;
                    e_h      = hh;
                    e_v      = vv;
                    er       = fs_err;
                end
                if (mode == 3 && v == 1 && h == 5) begin
                    de = 1'b1;
                    er = 1'b1;
                    x  = 0;
                    y  = 0;
                end
                if (mode == 2 && row == RST_ROW && h == H_ACT + 1) begin
                    rst      = 1'b1;
                    e_locked = 0;
                    e_h      = 0;
                    e_v      = 0;
                    b_sum    = 24'd0;
                    e_ck     = 24'd0;
                    step(1'b0, hs, vs, 1'b0, 1'b0, 0, 0);
                    rst = 1'b0;
                    chk_reset_zero();
                    yoff = -(RST_ROW + 1);
                end else begin
                    step(de, hs, vs, fs, er, x, y);
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        chk_reset_zero();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);

        gen_frame(0, 1'b0, 0, 0, 0);             // first VS edge: measuring starts
        gen_frame(0, 1'b0, 0, H_ACT, V_ACT);     // first good geometry stored
        gen_frame(1, 1'b0, 1, H_ACT, V_ACT);     // lock on 3rd frame_start; this frame has a short line
        gen_frame(0, 1'b1, 0, H_ACT, V_ACT);     // short line reported, lock lost, geometry held
        gen_frame(2, 1'b0, 0, H_ACT, V_ACT);     // reset pulse mid-frame
        gen_frame(0, 1'b0, 0, 0, 0);             // partial frame discarded
        gen_frame(0, 1'b0, 0, H_ACT, V_ACT);
        gen_frame(3, 1'b0, 1, H_ACT, V_ACT);     // relocked; DE while VS active
        gen_frame(0, 1'b1, 0, H_ACT, V_ACT);     // stray run makes that frame bad
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/vid_sync_rx.md
VID_SYNC_RX -- requirements
Module: vid_sync_rx

Interface
REQ-001 SHALL have parameter HS_POL, default 0, HS active level (0 = active-low).
REQ-002 SHALL have parameter VS_POL, default 0, VS active level (0 = active-low).
REQ-003 SHALL have parameter LOCK_FRAMES, default 2, consecutive matching frames required for lock (1..15).
REQ-004 SHALL have ports, clock and reset first:
 clk_25  in  1  pixel clock; all logic on rising edge
 rst  in  1  synchronous, active-high reset
 vid_de  in  1  data enable
 vid_hs  in  1  horizontal sync
 vid_vs  in  1  vertical sync
 vid_data  in  24  RGB888 pixel {R,G,B}
 pix_valid  out  1  registered copy of vid_de
 pix_data  out  24  registered copy of vid_data
 pix_x  out  11  column of pix_data, 0-based
 pix_y  out  11  row of pix_data, 0-based
 frame_start  out  1  one-cycle pulse on VS active edge
 h_active  out  11  measured pixels per line, last completed frame
 v_active  out  11  measured lines, last completed frame
 locked  out  1  geometry stable
 err  out  1  one-cycle pulse on geometry violation

Function
REQ-005 SHALL register all inputs once; pix_valid, pix_data, pix_x and pix_y SHALL appear 1 cycle after the sampled vid_de/vid_data.
REQ-006 SHALL detect the VS active edge (inactive->active per VS_POL) and pulse frame_start in the same cycle as the first registered output following that edge.
REQ-007 pix_x SHALL be 0 on the first DE-high cycle of a run and SHALL increment by 1 per DE-high cycle, saturating at 2047.
REQ-008 pix_y SHALL be 0 for the first DE run after frame_start and SHALL increment by 1 on each DE falling edge, saturating at 2047.
REQ-009 On each DE falling edge, the run length SHALL be compared against the first run of the current frame; inequality SHALL mark the frame bad.
REQ-010 On frame_start, the previous frame's run length and line count SHALL load into h_active/v_active only if that frame had ≥1 line and was not bad.
REQ-011 FSM states SHALL be SEARCH, MEASURE and LOCKED; locked=1 only in LOCKED.
REQ-012 SEARCH->MEASURE on first frame_start; match counter cleared.
REQ-013 MEASURE: at frame_start, a good frame equal to stored h_active/v_active SHALL increment the counter; otherwise the counter SHALL be set to 1 and the new geometry stored. At counter == LOCK_FRAMES -> LOCKED.
REQ-014 LOCKED: a bad frame, a differing geometry, or a zero-line frame SHALL pulse err and go to SEARCH, holding h_active/v_active.
REQ-015 DE high while VS active SHALL pulse err in every state; the pixel is still output and counted.
REQ-016 HS SHALL be used only to clear the run counter on its active edge; it SHALL NOT affect pix_y.
REQ-017 Simultaneous VS active edge and DE falling edge: line closure SHALL be applied to the ending frame first, then frame_start processing.

Reset
REQ-018 While rst=1: state SEARCH; pix_valid, frame_start, locked, err = 0; pix_x, pix_y, h_active, v_active, counter = 0; pix_data = 0; edge detectors SHALL load the current inputs so that no spurious edge is seen after reset.
REQ-019 Reset asserted mid-frame SHALL discard the partial frame; the first frame_start after release SHALL enter MEASURE.

Configuration
REQ-020 With VID_SYNC_RX_CKSUM_EN defined: output frame_cksum[23:0] = sum mod 2^24 of all DE-high vid_data values of the last completed frame, updated at frame_start and reset to 0.
REQ-021 Without VID_SYNC_RX_CKSUM_EN: the port and the adder SHALL be absent; all other behaviour is identical.

Verification
REQ-022 Reset, then 3 frames of 640x480 (800x525 total, active-low syncs) -> locked=1 after the 3rd frame_start; h_active=640, v_active=480; err never pulses.
REQ-023 While locked, line 100 driven with 639 DE cycles -> err pulses once at the next frame_start; locked=0; h_active stays 640.
REQ-024 Pixel stream check: DE rising at cycle T -> pix_valid=1, pix_x=0 at T+1; last pixel -> pix_x=639, pix_y=479.
REQ-025 rst pulsed for 1 cycle at line 200 -> all outputs 0; no frame_start until the next VS edge; relock after LOCK_FRAMES+1 frame_starts.
REQ-026 CKSUM_EN, all pixels 24'h000001 at 640x480 -> frame_cksum=307200 (24'h04B000); with HS_POL=VS_POL=1 and inverted syncs, the same results as REQ-022.
